// File: rtl/rv_mem_arbiter_pkg.sv
// rtl/rv_mem_arbiter_pkg.sv - shared core types for the IF/LSU memory arbiter
package rv_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESP   = 2'd2,
    REJECT = 2'd3
  } t_arb_state;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } t_arb_owner;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } t_mem_req;

  // Sub-word enables need an even address; full words need word alignment.
  function automatic logic be_legal(input logic [3:0] be, input logic [1:0] addr_lo);
    logic r_ok;
    r_ok = 1'b0;
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100: r_ok = ~addr_lo[0];
      4'b1111:          r_ok = (addr_lo == 2'b00);
      default:          r_ok = 1'b0;
    endcase
    return r_ok;
  endfunction

endpackage

// File: rtl/rv_mem_arb_pick.sv
// rtl/rv_mem_arb_pick.sv - winner selection between IF and LSU plus starvation counter update
module rv_mem_arb_pick
  import rv_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       i_if_req,
  input  logic       i_lsu_req,
  input  logic [3:0] i_starve_cnt,
  output logic       o_valid,
  output t_arb_owner o_owner,
  output logic [3:0] o_starve_nxt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic w_if_forced;

  assign w_if_forced = i_if_req && (i_starve_cnt == LIMIT);

  always_comb begin
    o_valid      = i_if_req | i_lsu_req;
    o_owner      = OWN_IF;
    o_starve_nxt = i_starve_cnt;
    if (i_lsu_req && !w_if_forced) begin
      o_owner = OWN_LSU;
    end
    if (o_valid) begin
      if (o_owner == OWN_IF) begin
        o_starve_nxt = 4'd0;
      end else if (i_if_req && (i_starve_cnt != LIMIT)) begin
        o_starve_nxt = i_starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// rtl/rv_mem_arbiter.sv - shares one memory port between instruction fetch and the LSU
module rv_mem_arbiter
  import rv_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        lsu_req,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_we,
  input  logic [3:0]  lsu_be,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  t_arb_state r_state;
  t_arb_state w_state_nxt;
  t_arb_owner r_owner;
  logic [3:0] r_starve_cnt;
  t_mem_req   r_mem;
  logic       r_mem_req;

  logic       w_pick_valid;
  t_arb_owner w_pick_owner;
  logic [3:0] w_starve_nxt;
  t_mem_req   w_win;
  logic       w_win_legal;

  logic        w_gnt;
  logic        w_rvalid;
  logic        w_err;
  logic [31:0] w_rdata;

  rv_mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .i_if_req    (if_req),
    .i_lsu_req   (lsu_req),
    .i_starve_cnt(r_starve_cnt),
    .o_valid     (w_pick_valid),
    .o_owner     (w_pick_owner),
    .o_starve_nxt(w_starve_nxt)
  );

  // Fetch is a word read, so its legality check reduces to word alignment.
  always_comb begin
    w_win = '0;
    if (w_pick_owner == OWN_LSU) begin
      w_win.addr  = lsu_addr;
      w_win.we    = lsu_we;
      w_win.be    = lsu_be;
      w_win.wdata = lsu_wdata;
    end else begin
      w_win.addr  = if_addr;
      w_win.we    = 1'b0;
      w_win.be    = 4'b1111;
      w_win.wdata = 32'h0;
    end
    w_win_legal = be_legal(w_win.be, w_win.addr[1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (w_pick_valid) w_state_nxt = w_win_legal ? ISSUE : REJECT;
      ISSUE:  if (mem_gnt) w_state_nxt = RESP;
      RESP:   if (mem_rvalid) w_state_nxt = IDLE;
      REJECT: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= OWN_IF;
      r_starve_cnt <= 4'd0;
      r_mem        <= '0;
      r_mem_req    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_owner      <= w_pick_owner;
            r_starve_cnt <= w_starve_nxt;
            if (w_win_legal) begin
              r_mem_req   <= 1'b1;
              r_mem.addr  <= {w_win.addr[31:2], 2'b00};
              r_mem.we    <= w_win.we;
              r_mem.be    <= w_win.be;
              r_mem.wdata <= w_win.wdata;
            end
          end
        end
        ISSUE: if (mem_gnt) r_mem_req <= 1'b0;
        default: ;
      endcase
    end
  end

  // Responses are produced once and steered to whoever owns the transaction.
  always_comb begin
    w_gnt    = 1'b0;
    w_rvalid = 1'b0;
    w_err    = 1'b0;
    w_rdata  = 32'h0;
    case (r_state)
      ISSUE: w_gnt = mem_gnt;
      RESP: begin
        if (mem_rvalid) begin
          w_rvalid = 1'b1;
          w_rdata  = r_mem.we ? 32'h0 : mem_rdata;
        end
      end
      REJECT: begin
        w_gnt    = 1'b1;
        w_rvalid = 1'b1;
        w_err    = 1'b1;
      end
      default: ;
    endcase

    if_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    if_err     = 1'b0;
    if_rdata   = 32'h0;
    lsu_gnt    = 1'b0;
    lsu_rvalid = 1'b0;
    lsu_err    = 1'b0;
    lsu_rdata  = 32'h0;
    if (r_owner == OWN_LSU) begin
      lsu_gnt    = w_gnt;
      lsu_rvalid = w_rvalid;
      lsu_err    = w_err;
      lsu_rdata  = w_rdata;
    end else begin
      if_gnt     = w_gnt;
      if_rvalid  = w_rvalid;
      if_err     = w_err;
      if_rdata   = w_rdata;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem.addr;
  assign mem_we    = r_mem.we;
  assign mem_be    = r_mem.be;
  assign mem_wdata = r_mem.wdata;

  a_rvalid_after_gnt: assert property (@(posedge clk) disable iff (rst)
    !(r_state == ISSUE && mem_gnt && mem_rvalid));

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb/tb_rv_mem_arbiter.sv - table-driven scoreboard bench for rv_mem_arbiter
module tb_rv_mem_arbiter;
  import rv_mem_arbiter_pkg::*;

  localparam int STARVE_LIMIT = 4;
  localparam int NVEC = 13;

  typedef struct packed {
    logic        is_lsu;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        exp_err;
    logic [31:0] exp_maddr;
  } vec_t;

  typedef struct packed {
    logic        is_lsu;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wd;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        lsu_req = 1'b0;
  logic [31:0] lsu_addr = 32'h0;
  logic        lsu_we = 1'b0;
  logic [3:0]  lsu_be = 4'h0;
  logic [31:0] lsu_wdata = 32'h0;
  logic        lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int          errors = 0;
  int          checks = 0;
  int          gnt_wait = 0;
  int          rv_delay = 1;
  logic [31:0] rd_value = 32'h0;
  bit          stray_rv = 1'b0;
  bit          sb_on = 1'b1;
  resp_t       exp_q[$];
  mreq_t       mreq_q[$];
  vec_t        vecs[NVEC];

  always #5 clk = ~clk;

  rv_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_we(lsu_we), .lsu_be(lsu_be),
    .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: grants after gnt_wait cycles, answers rv_delay cycles after the grant.
  initial begin : responder
    logic        acc;
    logic [31:0] r_dat;
    int          waitc;
    int          rvc;
    acc = 1'b0; r_dat = 32'h0; waitc = 0; rvc = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      acc = mem_gnt && mem_req;
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      if (acc) begin
        rvc = rv_delay; r_dat = rd_value; waitc = 0;
      end
      if (rvc > 0) begin
        rvc--;
        if (rvc == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = r_dat;
        end
      end
      if (mem_req) begin
        if (waitc >= gnt_wait) mem_gnt = 1'b1;
        else begin
          waitc++;
          if (waitc == 2) mem_rvalid = 1'b1;
        end
      end else begin
        waitc = 0;
      end
      if (stray_rv) mem_rvalid = 1'b1;
    end
  end

  initial begin : monitor
    mreq_t       cap;
    mreq_t       em;
    resp_t       er;
    logic        prev;
    logic [31:0] nq;
    cap = '0; em = '0; er = '0; prev = 1'b0; nq = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev) begin
        cap.addr = mem_addr; cap.we = mem_we; cap.be = mem_be; cap.wdata = mem_wdata;
        if (sb_on) begin
          if (mreq_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_req: got addr 0x%0h required no request", mem_addr);
          end else begin
            em = mreq_q.pop_front();
            check("mem_addr", mem_addr, em.addr);
            check("mem_we", 32'(mem_we), 32'(em.we));
            check("mem_be", 32'(mem_be), 32'(em.be));
            if (em.chk_wd) check("mem_wdata", mem_wdata, em.wdata);
          end
        end
      end else if (mem_req && prev) begin
        check("mem_addr_stable", mem_addr, cap.addr);
        check("mem_ctl_stable", {27'b0, mem_we, mem_be}, {27'b0, cap.we, cap.be});
        check("mem_wdata_stable", mem_wdata, cap.wdata);
      end
      prev = mem_req;
      if (if_rvalid || lsu_rvalid) begin
        check("single_rvalid", 32'(if_rvalid & lsu_rvalid), 32'h0);
        if (sb_on) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rvalid: got if=%0b lsu=%0b required none", if_rvalid, lsu_rvalid);
          end else begin
            er = exp_q.pop_front();
            check("resp_owner", 32'(lsu_rvalid), 32'(er.is_lsu));
            check("resp_rdata", lsu_rvalid ? lsu_rdata : if_rdata, er.rdata);
            check("resp_err", 32'(lsu_rvalid ? lsu_err : if_err), 32'(er.err));
            nq = er.is_lsu ? (if_rdata | {29'b0, if_gnt, if_rvalid, if_err})
                           : (lsu_rdata | {29'b0, lsu_gnt, lsu_rvalid, lsu_err});
            check("nonowner_quiet", nq, 32'h0);
          end
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_mem_ctl"}, {26'b0, mem_req, mem_we, mem_be}, 32'h0);
    check({tag, "_if_rdata"}, if_rdata, 32'h0);
    check({tag, "_lsu_rdata"}, lsu_rdata, 32'h0);
    check({tag, "_flags"}, {26'b0, if_gnt, if_rvalid, if_err, lsu_gnt, lsu_rvalid, lsu_err}, 32'h0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    check({tag, "_resp_drained"}, 32'(exp_q.size()), 32'h0);
    check({tag, "_mreq_drained"}, 32'(mreq_q.size()), 32'h0);
    exp_q.delete();
    mreq_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    resp_t r;
    mreq_t m;
    int    lat;
    bit    seen;
    r.is_lsu = v.is_lsu;
    r.err    = v.exp_err;
    r.rdata  = (v.exp_err || v.we) ? 32'h0 : v.rd;
    exp_q.push_back(r);
    if (!v.exp_err) begin
      m.addr   = v.exp_maddr;
      m.we     = v.is_lsu ? v.we : 1'b0;
      m.be     = v.is_lsu ? v.be : 4'hF;
      m.wdata  = v.wdata;
      m.chk_wd = v.is_lsu;
      mreq_q.push_back(m);
    end
    @(posedge clk); #1;
    rd_value = v.rd;
    if (v.is_lsu) begin
      lsu_req = 1'b1; lsu_addr = v.addr; lsu_we = v.we; lsu_be = v.be; lsu_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    lat = 0; seen = 1'b0;
    while (!seen && lat < 50) begin
      @(negedge clk);
      lat++;
      seen = v.is_lsu ? lsu_gnt : if_gnt;
      if (seen && v.exp_err)
        check("reject_rvalid_err", v.is_lsu ? {30'b0, lsu_rvalid, lsu_err} : {30'b0, if_rvalid, if_err}, 32'h3);
    end
    check("gnt_latency", 32'(lat), 32'(2 + gnt_wait));
    @(posedge clk); #1;
    if_req = 1'b0; lsu_req = 1'b0;
    drain("vec");
  endtask

  initial begin : stimulus
    int  got[10];
    int  n;
    int  cnt;
    int  exp_who;
    int  lat;
    mreq_t m;

    vecs[0]  = '{1'b0, 32'h0040_0004, 1'b0, 4'hF, 32'h0,         32'h0050_0093, 1'b0, 32'h0040_0004};
    vecs[1]  = '{1'b1, 32'h1001_0002, 1'b1, 4'hC, 32'hABCD_0000, 32'h1234_5678, 1'b0, 32'h1001_0000};
    vecs[2]  = '{1'b1, 32'h1001_0001, 1'b0, 4'h3, 32'h0,         32'h5555_5555, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h0040_0002, 1'b0, 4'hF, 32'h0,         32'h6666_6666, 1'b1, 32'h0};
    vecs[4]  = '{1'b1, 32'h1001_0004, 1'b0, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0, 32'h1001_0004};
    vecs[5]  = '{1'b1, 32'h1001_0006, 1'b0, 4'hF, 32'h0,         32'h7777_7777, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'h1001_0002, 1'b0, 4'h4, 32'h0,         32'h0BAD_BEEF, 1'b0, 32'h1001_0000};
    vecs[7]  = '{1'b1, 32'h1001_0000, 1'b0, 4'h6, 32'h0,         32'h8888_8888, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 32'h7FFF_EFFC, 1'b1, 4'h1, 32'h0000_00AA, 32'h1111_1111, 1'b0, 32'h7FFF_EFFC};
    vecs[9]  = '{1'b1, 32'h1001_0000, 1'b0, 4'h0, 32'h0,         32'h9999_9999, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'h0040_0001, 1'b0, 4'hF, 32'h0,         32'h4444_4444, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 32'hFFFF_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h2222_2222, 1'b0, 32'hFFFF_0010};
    vecs[12] = '{1'b1, 32'hFFFF_000E, 1'b0, 4'hC, 32'h0,         32'h8765_4321, 1'b0, 32'hFFFF_000C};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_state", 32'(dut.r_state), 32'(IDLE));
    check("reset_starve", 32'(dut.r_starve_cnt), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Memory stalls the grant for five cycles; a stray rvalid arrives mid-stall.
    gnt_wait = 5;
    run_vec('{1'b1, 32'h1001_0008, 1'b0, 4'hF, 32'h0, 32'h1357_9BDF, 1'b0, 32'h1001_0008});
    gnt_wait = 0;

    @(negedge clk);
    stray_rv = 1'b1;
    @(posedge clk); #2;
    stray_rv = 1'b0;
    @(negedge clk);
    check("idle_stray_rvalid", {30'b0, if_rvalid, lsu_rvalid}, 32'h0);
    check("idle_stray_state", 32'(dut.r_state), 32'(IDLE));

    // Both requesters hold req continuously; grant order follows the starvation rule.
    sb_on = 1'b0;
    n = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0040_0000;
    lsu_req = 1'b1; lsu_addr = 32'h1001_0000; lsu_we = 1'b0; lsu_be = 4'hF; lsu_wdata = 32'h0;
    for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
      @(negedge clk);
      if (lsu_gnt && n < 10) begin
        got[n] = 1; n++;
      end
      if (if_gnt && n < 10) begin
        got[n] = 0; n++;
        check("starve_cleared", 32'(dut.r_starve_cnt), 32'h0);
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0; lsu_req = 1'b0;
    check("starve_grants_seen", 32'(n), 32'd10);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      exp_who = (cnt == STARVE_LIMIT) ? 0 : 1;
      cnt = (exp_who == 0) ? 0 : cnt + 1;
      check("starve_order", 32'(got[i]), 32'(exp_who));
    end
    repeat (4) @(negedge clk);
    sb_on = 1'b1;
    exp_q.delete();
    mreq_q.delete();

    // Reset while waiting for the response: the late rvalid must go nowhere.
    rv_delay = 4;
    m.addr = 32'h0040_0008; m.we = 1'b0; m.be = 4'hF; m.wdata = 32'h0; m.chk_wd = 1'b0;
    mreq_q.push_back(m);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0040_0008;
    lat = 0;
    while (!if_gnt && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("rst_case_gnt_latency", 32'(lat), 32'd2);
    @(posedge clk); #1;
    if_req = 1'b0;
    check("rst_case_in_resp", 32'(dut.r_state), 32'(RESP));
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_rvalid", {30'b0, if_rvalid, lsu_rvalid}, 32'h0);
    end
    check("rst_state_idle", 32'(dut.r_state), 32'(IDLE));
    check_idle_outputs("post_rst");
    rv_delay = 1;
    drain("rst_case");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout required bench completion");
    $fatal;
  end

endmodule
